// File: rtl/lpc_host.sv
// ---------------------------------------------------------------------------
// lpc_host -- LPC host controller for single-byte I/O read and write cycles.
//
// Drives START, CYCTYPE, ADDR, (WDATA), HTAR on LAD, then waits for the
// peripheral SYNC. A read captures two data nibbles. Every cycle ends with a
// peripheral turnaround and a one-cycle Done pulse.
//
// Optional feature macro: LPC_HOST_ABORT_EN. When it is defined, a SYNC
// timeout drives the LPC abort pattern (LFRAME# low with LAD=1111 for 4
// cycles). When it is undefined, a timeout ends the cycle quietly.
//
// Ports:
//   i_LpcClock  33 MHz LPC clock (single domain)
//   i_PciReset  synchronous active-high reset
//   i_Req       request; i_ReqWr/i_ReqAddr/i_ReqData are latched on START
//   i_ReqWr     1 = I/O write, 0 = I/O read
//   i_ReqAddr   16-bit I/O address
//   i_ReqData   write data
//   o_Busy      transaction in progress
//   o_Done      one-cycle completion pulse
//   o_Err       qualifies o_Done: SYNC error or timeout
//   o_RdData    read data, updated only when a read completes without error
//   o_LpcFrame  LFRAME#, active low
//   o_LadOut    LAD drive value
//   o_LadOe     LAD output enable (the pad tristate is outside this block)
//   i_LadIn     LAD sampled value
//
// All outputs are registered. They are decoded from the *next* state, so the
// bus shows state S during the cycle in which r_state == S. LAD is sampled at
// the edge that ends that bus cycle.
// ---------------------------------------------------------------------------
module lpc_host #(
  parameter int SYNC_TIMEOUT = 8,
  parameter int LWAIT_LIMIT  = 255
) (
  input  logic        i_LpcClock,
  input  logic        i_PciReset,
  input  logic        i_Req,
  input  logic        i_ReqWr,
  input  logic [15:0] i_ReqAddr,
  input  logic [7:0]  i_ReqData,
  output logic        o_Busy,
  output logic        o_Done,
  output logic        o_Err,
  output logic [7:0]  o_RdData,
  output logic        o_LpcFrame,
  output logic [3:0]  o_LadOut,
  output logic        o_LadOe,
  input  logic [3:0]  i_LadIn
);

  localparam int SW = $clog2(SYNC_TIMEOUT + 1);
  localparam int LW = $clog2(LWAIT_LIMIT + 1);
  localparam logic [SW-1:0] S_LAST = SW'(SYNC_TIMEOUT - 1);
  localparam logic [LW-1:0] L_LAST = LW'(LWAIT_LIMIT - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_CYCTYPE, S_ADDR, S_WDATA, S_HTAR,
    S_SYNC, S_RDATA, S_PTAR, S_ABORT, S_DONE
  } state_t;

  state_t        r_state, w_state_n;
  logic [1:0]    r_cnt,   w_cnt_n;     // nibble / phase index within a state
  logic [SW-1:0] r_scnt,  w_scnt_n;    // SYNC cycles without a valid code
  logic [LW-1:0] r_lcnt,  w_lcnt_n;    // consecutive long-wait SYNC cycles
  logic          r_err,   w_err_n;
  logic [7:0]    r_rbuf,  w_rbuf_n;    // read shadow; copied out on DONE
  logic          r_wr;
  logic [15:0]   r_addr;
  logic [7:0]    r_data;
`ifdef LPC_HOST_ABORT_EN
  logic [2:0]    r_acnt,  w_acnt_n;
`endif

  // Output values for the next cycle.
  logic       w_frame_n, w_oe_n, w_busy_n, w_done_n, w_err_out_n;
  logic [3:0] w_lad_n;

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_scnt_n  = r_scnt;
    w_lcnt_n  = r_lcnt;
    w_err_n   = r_err;
    w_rbuf_n  = r_rbuf;
`ifdef LPC_HOST_ABORT_EN
    w_acnt_n  = r_acnt;
`endif
    case (r_state)
      S_IDLE: begin
        if (i_Req) begin
          w_state_n = S_START;
          w_cnt_n   = '0;
          w_scnt_n  = '0;
          w_lcnt_n  = '0;
          w_err_n   = 1'b0;
`ifdef LPC_HOST_ABORT_EN
          w_acnt_n  = '0;
`endif
        end
      end
      S_START:   w_state_n = S_CYCTYPE;
      S_CYCTYPE: begin
        w_state_n = S_ADDR;
        w_cnt_n   = '0;
      end
      S_ADDR: begin
        if (r_cnt == 2'd3) begin
          w_state_n = r_wr ? S_WDATA : S_HTAR;
          w_cnt_n   = '0;
        end else begin
          w_cnt_n = r_cnt + 2'd1;
        end
      end
      S_WDATA: begin
        if (r_cnt[0]) begin
          w_state_n = S_HTAR;
          w_cnt_n   = '0;
        end else begin
          w_cnt_n = 2'd1;
        end
      end
      S_HTAR: begin
        if (r_cnt[0]) begin
          w_state_n = S_SYNC;
          w_cnt_n   = '0;
          w_scnt_n  = '0;
          w_lcnt_n  = '0;
        end else begin
          w_cnt_n = 2'd1;
        end
      end
      S_SYNC: begin
        case (i_LadIn)
          4'b0000: begin
            w_state_n = r_wr ? S_PTAR : S_RDATA;
            w_cnt_n   = '0;
          end
          4'b0110: begin
            // A long wait restarts the short-wait budget.
            w_scnt_n = '0;
            if (r_lcnt == L_LAST) begin
              w_err_n   = 1'b1;
              w_state_n = S_ABORT;
            end else begin
              w_lcnt_n = r_lcnt + 1'b1;
            end
          end
          4'b1010: begin
            // Peripheral error: read data is not transferred.
            w_err_n   = 1'b1;
            w_state_n = S_PTAR;
            w_cnt_n   = '0;
          end
          default: begin
            // Short wait (0101) and unknown codes share the timeout budget.
            w_lcnt_n = '0;
            if (r_scnt == S_LAST) begin
              w_err_n   = 1'b1;
              w_state_n = S_ABORT;
            end else begin
              w_scnt_n = r_scnt + 1'b1;
            end
          end
        endcase
      end
      S_RDATA: begin
        if (r_cnt[0]) begin
          w_rbuf_n[7:4] = i_LadIn;
          w_state_n     = S_PTAR;
          w_cnt_n       = '0;
        end else begin
          w_rbuf_n[3:0] = i_LadIn;
          w_cnt_n       = 2'd1;
        end
      end
      S_PTAR: begin
        if (r_cnt[0]) begin
          w_state_n = S_DONE;
          w_cnt_n   = '0;
        end else begin
          w_cnt_n = 2'd1;
        end
      end
      S_ABORT: begin
`ifdef LPC_HOST_ABORT_EN
        // Counts 0..3 drive the abort pattern, count 4 releases the bus.
        if (r_acnt == 3'd4) w_state_n = S_DONE;
        else                w_acnt_n  = r_acnt + 3'd1;
`else
        w_state_n = S_DONE;
`endif
      end
      S_DONE:  w_state_n = S_IDLE;
      default: w_state_n = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Output decode from the next state
  // -------------------------------------------------------------------------
  always_comb begin
    w_frame_n   = 1'b1;
    w_lad_n     = 4'hF;
    w_oe_n      = 1'b0;
    w_busy_n    = 1'b1;
    w_done_n    = 1'b0;
    w_err_out_n = 1'b0;
    case (w_state_n)
      S_IDLE:  w_busy_n = 1'b0;
      S_START: begin
        w_frame_n = 1'b0;
        w_lad_n   = 4'h0;
        w_oe_n    = 1'b1;
      end
      S_CYCTYPE: begin
        w_lad_n = r_wr ? 4'b0010 : 4'b0000;
        w_oe_n  = 1'b1;
      end
      S_ADDR: begin
        w_oe_n = 1'b1;
        case (w_cnt_n)
          2'd0:    w_lad_n = r_addr[15:12];
          2'd1:    w_lad_n = r_addr[11:8];
          2'd2:    w_lad_n = r_addr[7:4];
          default: w_lad_n = r_addr[3:0];
        endcase
      end
      S_WDATA: begin
        w_oe_n  = 1'b1;
        w_lad_n = w_cnt_n[0] ? r_data[7:4] : r_data[3:0];
      end
      S_HTAR:  w_oe_n = ~w_cnt_n[0];  // drive 1111 first, then release
      S_ABORT: begin
`ifdef LPC_HOST_ABORT_EN
        if (w_acnt_n != 3'd4) begin
          w_frame_n = 1'b0;
          w_oe_n    = 1'b1;
        end
`endif
      end
      S_DONE: begin
        w_busy_n    = 1'b0;
        w_done_n    = 1'b1;
        w_err_out_n = w_err_n;
      end
      default: ;
    endcase
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge i_LpcClock) begin
    if (i_PciReset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_scnt     <= '0;
      r_lcnt     <= '0;
      r_err      <= 1'b0;
      r_rbuf     <= '0;
      r_wr       <= 1'b0;
      r_addr     <= '0;
      r_data     <= '0;
`ifdef LPC_HOST_ABORT_EN
      r_acnt     <= '0;
`endif
      o_LpcFrame <= 1'b1;
      o_LadOut   <= 4'hF;
      o_LadOe    <= 1'b0;
      o_Busy     <= 1'b0;
      o_Done     <= 1'b0;
      o_Err      <= 1'b0;
      o_RdData   <= '0;
    end else begin
      r_state    <= w_state_n;
      r_cnt      <= w_cnt_n;
      r_scnt     <= w_scnt_n;
      r_lcnt     <= w_lcnt_n;
      r_err      <= w_err_n;
      r_rbuf     <= w_rbuf_n;
`ifdef LPC_HOST_ABORT_EN
      r_acnt     <= w_acnt_n;
`endif
      // Request fields are captured once, on the edge that enters START.
      if (r_state == S_IDLE && i_Req) begin
        r_wr   <= i_ReqWr;
        r_addr <= i_ReqAddr;
        r_data <= i_ReqData;
      end
      o_LpcFrame <= w_frame_n;
      o_LadOut   <= w_lad_n;
      o_LadOe    <= w_oe_n;
      o_Busy     <= w_busy_n;
      o_Done     <= w_done_n;
      o_Err      <= w_err_out_n;
      // Read data becomes visible together with a clean read completion.
      if (w_state_n == S_DONE && !r_wr && !w_err_n)
        o_RdData <= w_rbuf_n;
    end
  end

endmodule

// File: doc/lpc_host.md
LPC_HOST -- requirements
Module: lpc_host

Interface
REQ-001 Parameter SYNC_TIMEOUT, default 8: max SYNC cycles with no valid SYNC code (short waits 0101 count) before timeout.
REQ-002 Parameter LWAIT_LIMIT, default 255: max consecutive long-wait (0110) SYNC cycles before timeout.
REQ-003 LpcClock  in  1  33 MHz LPC clock; single clock domain.
REQ-004 PciReset  in  1  reset; synchronous, active-high.
REQ-005 Req  in  1  transaction request; Req, ReqWr, ReqAddr and ReqData are held stable until Done.
REQ-006 ReqWr  in  1  1 = I/O write, 0 = I/O read.
REQ-007 ReqAddr  in  16  I/O address.
REQ-008 ReqData  in  8  write data.
REQ-009 Busy  out  1  transaction in progress.
REQ-010 Done  out  1  one-cycle completion pulse.
REQ-011 Err  out  1  qualifies Done: SYNC error or timeout.
REQ-012 RdData  out  8  read data, valid with Done when ReqWr=0 and Err=0.
REQ-013 LpcFrame  out  1  LFRAME#, active-low.
REQ-014 LadOut  out  4  LAD drive value.
REQ-015 LadOe  out  1  LAD output enable; pad tristate lives outside this block.
REQ-016 LadIn  in  4  LAD sampled value.

Function
REQ-017 All outputs SHALL be registered; the FSM SHALL have states IDLE, START, CYCTYPE, ADDR, WDATA, HTAR, SYNC, RDATA, PTAR, ABORT, DONE.
REQ-018 IDLE: LpcFrame=1, LadOe=0, Busy=0; Req=1 sampled at edge k SHALL enter START at k+1 with Busy=1.
REQ-019 START: 1 cycle, LpcFrame=0, LadOut=0000, LadOe=1.
REQ-020 CYCTYPE: 1 cycle, LpcFrame=1, LadOut=0010 (write) or 0000 (read).
REQ-021 ADDR: 4 cycles, ReqAddr nibbles [15:12], [11:8], [7:4], [3:0] in that order; a 2-bit counter SHALL index the nibble.
REQ-022 WDATA (write only): 2 cycles, ReqData[3:0] then ReqData[7:4].
REQ-023 HTAR: 2 cycles; cycle 1 LadOut=1111 with LadOe=1, cycle 2 LadOe=0.
REQ-024 SYNC: LadOe=0, LadIn sampled every cycle. 0000 ends SYNC (to RDATA for read, PTAR for write); 0101 counts toward SYNC_TIMEOUT; 0110 counts toward LWAIT_LIMIT, resetting the short counter; 1010 sets the error flag and goes to PTAR (read data skipped); any other code counts toward SYNC_TIMEOUT.
REQ-025 Timeout (either counter reaching its limit) SHALL set the error flag and go to ABORT.
REQ-026 RDATA: 2 cycles, LadIn captured low nibble first into RdData[3:0], then RdData[7:4].
REQ-027 PTAR: 2 cycles, LadOe=0, LadIn ignored.
REQ-028 DONE: 1 cycle, Done=1, Err=error flag, Busy=0; next state IDLE; RdData SHALL hold until the next read completes.
REQ-029 Minimum latency with immediate SYNC 0000: Done SHALL assert exactly 14 cycles after the Req-sampling edge, for both read and write.
REQ-030 Req asserted during DONE SHALL be ignored; a new transaction SHALL start only from IDLE, so back-to-back requests are separated by at least one IDLE cycle.
REQ-031 Changes to Req inputs while Busy=1 SHALL NOT affect the cycle in flight; all fields SHALL be latched on entering START.

Reset
REQ-032 PciReset=1 at any edge, including mid-transaction, SHALL force IDLE, LpcFrame=1, LadOe=0, LadOut=1111, Busy=0, Done=0, Err=0, RdData=8'h00, and clear all counters; no Done SHALL be issued for the killed cycle.

Configuration
REQ-033 With LPC_HOST_ABORT_EN defined, ABORT SHALL drive LpcFrame=0, LadOut=1111, LadOe=1 for 4 cycles, then 1 cycle LpcFrame=1 with LadOe=0, then DONE.
REQ-034 Without LPC_HOST_ABORT_EN, ABORT SHALL last one cycle with LpcFrame=1 and LadOe=0, then go to DONE; no abort pattern SHALL appear on the bus.

Verification
REQ-035 Write 0x55 to 0x0080, SYNC 0000 immediately -> LAD sequence 0000,0010,0,0,8,0,5,5,F,Z; Done at +14 cycles; Err=0.
REQ-036 Read 0x0062, SYNC 0000, peripheral drives 5 then A -> RdData=0xA5, Err=0, Done at +14 cycles.
REQ-037 Read with 3 cycles of 0110 then 0000 -> Done at +17 cycles, Err=0.
REQ-038 Write with SYNC 1010 -> PTAR, then Done with Err=1 at +14 cycles.
REQ-039 Read with LadIn stuck at 1111 -> timeout after 8 SYNC cycles; with the macro, 4-cycle LpcFrame=0/1111 abort appears, then Done with Err=1.
REQ-040 PciReset asserted during ADDR -> next cycle matches all REQ-032 values, no Done; a fresh Req then completes normally.
